dm_port_arbiter: RTL and testbench

- Sits between the M-stage memory port of the pipelined MIPS core and the single-port 4096-word data memory.
- Shares the memory with a second word-only master (loader/DMA port).
- Translates CPU sw/sh/sb into word index, byte enables and lane-shifted write data, and flags misaligned or out-of-range CPU accesses.
- Arbitrates between the two masters with CPU priority, a starvation guard, and a bounded DMA burst lock.

---
 rtl/dm_port_arbiter_pkg.sv | 23 ++
 rtl/dm_lane_gen.sv | 39 +++
 rtl/dm_port_arbiter.sv | 127 ++++++++++++
 tb/tb_dm_port_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_port_arbiter_pkg.sv
// Shared encodings and sizes for the data-memory port arbiter and its lane generator.
package dm_port_arbiter_pkg;

  localparam int DM_WORDS = 4096;
  localparam int DM_IDX_W = 12;

  typedef enum logic [1:0] {
    OP_WORD = 2'b00,
    OP_HALF = 2'b01,
    OP_BYTE = 2'b10,
    OP_ILL  = 2'b11
  } dm_op_e;

  typedef enum logic {
    NORMAL = 1'b0,
    LOCK   = 1'b1
  } arb_state_e;

  function automatic logic [3:0] byte_be(input logic [1:0] off);
    return 4'b0001 << off;
  endfunction

endpackage

// File: rtl/dm_lane_gen.sv
// CPU store lane generator: byte enables, lane-replicated write data and access-error flag.
module dm_lane_gen
  import dm_port_arbiter_pkg::*;
(
  input  logic [1:0]  i_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_err
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    o_be    = '0;
    o_wdata = i_wdata;
    o_err   = (i_addr[31:14] != '0);

    case (dm_op_e'(i_op))
      OP_WORD: begin
        o_err = o_err | (i_addr[1:0] != 2'b00);
        o_be  = 4'b1111;
      end
      OP_HALF: begin
        o_err   = o_err | i_addr[0];
        o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      OP_BYTE: begin
        o_be    = byte_be(i_addr[1:0]);
        o_wdata = {4{i_wdata[7:0]}};
      end
      default: o_err = 1'b1;
    endcase

    if (o_err) o_be = '0;
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single-port data memory between the CPU M-stage port and a word-only DMA port.
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int MAX_CPU_WINS = 3,
  parameter int MAX_BURST    = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                c_req,
  input  logic                c_we,
  input  logic [1:0]          c_op,
  input  logic [31:0]         c_addr,
  input  logic [31:0]         c_wdata,
  output logic                c_gnt,
  output logic                c_err,
  output logic [31:0]         c_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic                d_burst,
  input  logic [DM_IDX_W-1:0] d_addr,
  input  logic [31:0]         d_wdata,
  output logic                d_gnt,
  output logic [31:0]         d_rdata,
  output logic [DM_IDX_W-1:0] mem_addr,
  output logic                mem_we,
  output logic [3:0]          mem_be,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata
);

  localparam int WIN_W  = $clog2(MAX_CPU_WINS + 1);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [WIN_W-1:0]  WIN_MAX  = WIN_W'(MAX_CPU_WINS);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST);

  arb_state_e        r_state, w_state_nx;
  logic [WIN_W-1:0]  r_win_cnt, w_win_nx;
  logic [BEAT_W-1:0] r_beat_cnt, w_beat_nx;
  logic              w_cpu_sel, w_dma_sel, w_lock_hold, w_lock_exit;
  logic [3:0]        w_lane_be;
  logic [31:0]       w_lane_wdata;
  logic              w_lane_err;

  dm_lane_gen u_lane (
    .i_op    (c_op),
    .i_addr  (c_addr),
    .i_wdata (c_wdata),
    .o_be    (w_lane_be),
    .o_wdata (w_lane_wdata),
    .o_err   (w_lane_err)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= NORMAL;
      r_win_cnt  <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_win_cnt  <= w_win_nx;
      r_beat_cnt <= w_beat_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_win_nx    = r_win_cnt;
    w_beat_nx   = r_beat_cnt;
    w_cpu_sel   = 1'b0;
    w_dma_sel   = 1'b0;
    w_lock_exit = (r_state == LOCK);
    w_lock_hold = w_lock_exit && d_req && d_burst && (r_beat_cnt < BEAT_MAX);

    if (Reset) begin
      w_state_nx = NORMAL;
    end else if (w_lock_hold) begin
      w_dma_sel = 1'b1;
      w_beat_nx = r_beat_cnt + BEAT_W'(1);
    end else begin
      // Leaving a lock re-arbitrates this same cycle with plain CPU priority.
      if (w_lock_exit) begin
        w_state_nx = NORMAL;
        w_beat_nx  = '0;
        w_win_nx   = '0;
      end
      if (c_req && !(d_req && !w_lock_exit && r_win_cnt >= WIN_MAX)) begin
        w_cpu_sel = 1'b1;
        w_win_nx  = (d_req && !w_lock_exit) ? r_win_cnt + WIN_W'(1) : '0;
      end else if (d_req) begin
        w_dma_sel = 1'b1;
        w_win_nx  = '0;
        if (d_burst) begin
          w_state_nx = LOCK;
          w_beat_nx  = BEAT_W'(1);
        end
      end
    end
  end

  always_comb begin
    c_gnt     = w_cpu_sel;
    d_gnt     = w_dma_sel;
    c_err     = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_wdata = '0;
    c_rdata   = mem_rdata;
    d_rdata   = mem_rdata;

    if (w_cpu_sel) begin
      c_err     = w_lane_err;
      mem_addr  = c_addr[13:2];
      mem_we    = c_we && !w_lane_err;
      mem_be    = mem_we ? w_lane_be : 4'b0000;
      mem_wdata = w_lane_wdata;
    end else if (w_dma_sel) begin
      mem_addr  = d_addr;
      mem_we    = d_we;
      mem_be    = d_we ? 4'b1111 : 4'b0000;
      mem_wdata = d_wdata;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench: the driver queues hand-computed expectations, a negedge monitor compares them.
module tb_dm_port_arbiter;
  import dm_port_arbiter_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        c_req, c_we, c_gnt, c_err;
  logic [1:0]  c_op;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        d_req, d_we, d_burst, d_gnt;
  logic [11:0] d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 Clk = ~Clk;

  assign mem_rdata = 32'hC0DE_0000 | {20'h0, mem_addr};

  dm_port_arbiter #(.MAX_CPU_WINS(3), .MAX_BURST(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .c_req(c_req), .c_we(c_we), .c_op(c_op), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_err(c_err), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_burst(d_burst), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    int          id;
    logic        c_gnt, d_gnt, c_err, mem_we;
    logic [3:0]  be;
    bit          chk_addr;
    logic [11:0] addr;
    bit          chk_wd;
    logic [31:0] wdata;
    bit          chk_crd, chk_drd;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vid    = 0;

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s v%0d: got %h want %h", name, id, act, want);
    end
  endtask

  function automatic exp_t e_base();
    exp_t e;
    e.id = 0; e.c_gnt = 0; e.d_gnt = 0; e.c_err = 0; e.mem_we = 0; e.be = '0;
    e.chk_addr = 0; e.addr = '0; e.chk_wd = 0; e.wdata = '0;
    e.chk_crd = 0; e.chk_drd = 0; e.rdata = '0;
    return e;
  endfunction

  function automatic exp_t e_rst();
    exp_t e = e_base();
    e.chk_addr = 1; e.chk_wd = 1;
    return e;
  endfunction

  function automatic exp_t e_cpu(input logic err, input logic we, input logic [3:0] be,
                                 input bit chk_addr, input logic [11:0] addr,
                                 input bit chk_wd, input logic [31:0] wd);
    exp_t e = e_base();
    e.c_gnt = 1; e.c_err = err; e.mem_we = we; e.be = be;
    e.chk_addr = chk_addr; e.addr = addr; e.chk_wd = chk_wd; e.wdata = wd;
    return e;
  endfunction

  function automatic exp_t e_dma(input logic we, input logic [11:0] addr, input logic [31:0] wd);
    exp_t e = e_base();
    e.d_gnt = 1; e.mem_we = we; e.be = we ? 4'b1111 : 4'b0000;
    e.chk_addr = 1; e.addr = addr; e.chk_wd = we; e.wdata = wd;
    return e;
  endfunction

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic cpu_in(input logic req, input logic we, input logic [1:0] op,
                        input logic [31:0] addr, input logic [31:0] wd);
    c_req = req; c_we = we; c_op = op; c_addr = addr; c_wdata = wd;
  endtask

  task automatic dma_in(input logic req, input logic we, input logic burst,
                        input logic [11:0] addr, input logic [31:0] wd);
    d_req = req; d_we = we; d_burst = burst; d_addr = addr; d_wdata = wd;
  endtask

  task automatic push(input exp_t e);
    e.id = vid++;
    exp_q.push_back(e);
  endtask

  always @(negedge Clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("c_gnt",   e.id, 32'(c_gnt),  32'(e.c_gnt));
      check("d_gnt",   e.id, 32'(d_gnt),  32'(e.d_gnt));
      check("one_hot", e.id, 32'(c_gnt & d_gnt), 32'(0));
      check("c_err",   e.id, 32'(c_err),  32'(e.c_err));
      check("mem_we",  e.id, 32'(mem_we), 32'(e.mem_we));
      check("mem_be",  e.id, 32'(mem_be), 32'(e.be));
      if (e.chk_addr) check("mem_addr",  e.id, 32'(mem_addr), 32'(e.addr));
      if (e.chk_wd)   check("mem_wdata", e.id, mem_wdata, e.wdata);
      if (e.chk_crd)  check("c_rdata",   e.id, c_rdata, e.rdata);
      if (e.chk_drd)  check("d_rdata",   e.id, d_rdata, e.rdata);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    Reset = 1'b1;
    cpu_in(0, 0, OP_WORD, 32'h0, 32'h0);
    dma_in(0, 0, 0, 12'h0, 32'h0);

    repeat (2) begin
      next_cycle(); Reset = 1'b1; push(e_rst());
    end
    next_cycle(); Reset = 1'b0; push(e_base());

    // CPU-only directed accesses
    next_cycle(); cpu_in(1, 1, OP_BYTE, 32'h0000_0013, 32'h0000_00AB);
    push(e_cpu(0, 1, 4'b1000, 1, 12'h004, 1, 32'hABAB_ABAB));
    next_cycle(); cpu_in(1, 1, OP_HALF, 32'h0000_0006, 32'h0000_1234);
    push(e_cpu(0, 1, 4'b1100, 1, 12'h001, 1, 32'h1234_1234));
    next_cycle(); cpu_in(1, 1, OP_HALF, 32'h0000_0005, 32'h0000_1234);
    push(e_cpu(1, 0, 4'b0000, 0, 12'h0, 0, 32'h0));
    next_cycle(); cpu_in(1, 1, OP_WORD, 32'h0000_4000, 32'h5555_5555);
    push(e_cpu(1, 0, 4'b0000, 0, 12'h0, 0, 32'h0));
    next_cycle(); cpu_in(1, 1, OP_ILL, 32'h0000_0008, 32'h5555_5555);
    push(e_cpu(1, 0, 4'b0000, 0, 12'h0, 0, 32'h0));
    next_cycle(); cpu_in(1, 1, OP_WORD, 32'h0000_0010, 32'hDEAD_BEEF);
    push(e_cpu(0, 1, 4'b1111, 1, 12'h004, 1, 32'hDEAD_BEEF));
    next_cycle(); cpu_in(1, 1, OP_BYTE, 32'h0000_0020, 32'h0000_005A);
    push(e_cpu(0, 1, 4'b0001, 1, 12'h008, 1, 32'h5A5A_5A5A));
    next_cycle(); cpu_in(1, 0, OP_WORD, 32'h0000_3FFC, 32'h0);
    e = e_cpu(0, 0, 4'b0000, 1, 12'hFFF, 0, 32'h0);
    e.chk_crd = 1; e.rdata = 32'hC0DE_0FFF;
    push(e);

    // DMA-only accesses
    next_cycle(); cpu_in(0, 0, OP_WORD, 32'h0, 32'h0);
    dma_in(1, 1, 0, 12'h123, 32'hCAFE_F00D);
    push(e_dma(1, 12'h123, 32'hCAFE_F00D));
    next_cycle(); dma_in(1, 0, 0, 12'h007, 32'h0);
    e = e_dma(0, 12'h007, 32'h0);
    e.chk_drd = 1; e.rdata = 32'hC0DE_0007;
    push(e);

    // Contention without burst: C,C,C,D repeating
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      cpu_in(1, 1, OP_WORD, 32'h0000_0040, 32'h1111_1111);
      dma_in(1, 1, 0, 12'h050, 32'h2222_2222);
      if (i % 4 == 3) push(e_dma(1, 12'h050, 32'h2222_2222));
      else            push(e_cpu(0, 1, 4'b1111, 1, 12'h010, 1, 32'h1111_1111));
    end

    next_cycle(); cpu_in(0, 0, OP_WORD, 32'h0, 32'h0); dma_in(0, 0, 0, 12'h0, 32'h0);
    push(e_base());

    // Burst capped at 8 beats while the CPU waits, then the CPU wins
    for (int k = 0; k < 12; k++) begin
      logic [11:0] a;
      a = (k < 8) ? 12'(k) : 12'd8;
      next_cycle();
      cpu_in(k >= 1, 1, OP_WORD, 32'h0000_0080, 32'h3333_3333);
      dma_in(1, 1, 1, a, 32'hD000_0000 | 32'(a));
      if (k < 8) push(e_dma(1, a, 32'hD000_0000 | 32'(a)));
      else       push(e_cpu(0, 1, 4'b1111, 1, 12'h020, 1, 32'h3333_3333));
    end

    next_cycle(); cpu_in(0, 0, OP_WORD, 32'h0, 32'h0); dma_in(0, 0, 0, 12'h0, 32'h0);
    push(e_base());

    // Reset at beat 4 of a burst aborts it
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      cpu_in(k >= 1, 1, OP_WORD, 32'h0000_0080, 32'h4444_4444);
      dma_in(1, 1, 1, 12'h100 + 12'(k), 32'hE000_0000 | 32'(k));
      push(e_dma(1, 12'h100 + 12'(k), 32'hE000_0000 | 32'(k)));
    end
    repeat (2) begin
      next_cycle(); Reset = 1'b1;
      dma_in(1, 1, 1, 12'h104, 32'hE000_0004);
      push(e_rst());
    end
    repeat (2) begin
      next_cycle(); Reset = 1'b0;
      push(e_cpu(0, 1, 4'b1111, 1, 12'h020, 1, 32'h4444_4444));
    end

    next_cycle(); cpu_in(0, 0, OP_WORD, 32'h0, 32'h0); dma_in(0, 0, 0, 12'h0, 32'h0);
    push(e_base());

    @(negedge Clk);
    #1;
    check("queue_drained", 0, 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
